// File: rtl/addsub_seq_s_pkg.sv
// Shared types and defaults for the slice-serial signed adder/subtractor.
// State encodings are fixed so that checkers can decode the FSM directly.
package addsub_seq_s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  // A slice index needs at least one bit even when there are only two slices.
  function automatic int idx_bits(input int nslice);
    return (nslice <= 2) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/addsub_seq_s_slice.sv
// Combinational SLICE-bit adder used once per cycle by addsub_seq_s.
// c_msb is the carry into the slice's top bit, needed for signed overflow.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             ci,
  output logic [SLICE-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [SLICE:0]   full;
  logic [SLICE-1:0] low;

  assign full  = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};
  // Adding only the lower SLICE-1 bits exposes the carry into bit SLICE-1.
  assign low   = {1'b0, x[SLICE-2:0]} + {1'b0, y[SLICE-2:0]} + {{(SLICE-1){1'b0}}, ci};
  assign sum   = full[SLICE-1:0];
  assign co    = full[SLICE];
  assign c_msb = low[SLICE-1];

endmodule

// File: rtl/addsub_seq_s.sv
// Multi-cycle signed adder/subtractor: one SLICE-bit add per cycle through a
// shared slice adder, valid/ready on both operand and result sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its data stable while valid is high and ready
// is low, and valid never depends combinationally on ready.
module addsub_seq_s
  import addsub_seq_s_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = idx_bits(NSLICE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_r;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;

  logic [SLICE-1:0] sl_sum;
  logic             sl_co;
  logic             sl_cmsb;

  // Operands shift down so the active slice always sits in the low bits.
  adder_slice #(.SLICE(SLICE)) u_slice (
    .x     (a_sh[SLICE-1:0]),
    .y     (b_sh[SLICE-1:0]),
    .ci    (carry),
    .sum   (sl_sum),
    .co    (sl_co),
    .c_msb (sl_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      s_r    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= cin ^ sub;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> SLICE;
          b_sh  <= b_sh >> SLICE;
          // Each new slice enters at the top; after NSLICE shifts s is in place.
          s_r   <= {sl_sum, s_r[WIDTH-1:SLICE]};
          carry <= sl_co;
          if (idx == LAST_IDX) begin
            cout_r <= sl_co;
            ovf_r  <= sl_co ^ sl_cmsb;
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign s         = s_r;
  assign cout      = cout_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_addsub_seq_s.sv
// Self-checking bench for addsub_seq_s: 16/4 main instance plus a 32/8 instance.
module tb_addsub_seq_s;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, sub, cin;
  logic [15:0] a, b, s;
  logic        out_valid, out_ready, cout, overflow, busy;

  logic        in_valid32, in_ready32, sub32, cin32;
  logic [31:0] a32, b32, s32;
  logic        out_valid32, out_ready32, cout32, overflow32, busy32;

  int n_checks = 0;
  int n_errors = 0;
  int n_results = 0;
  int cyc = 0;
  int acc_edge = 0;
  logic ov_prev = 1'b0;
  logic [17:0] exp_q[$];
  logic [15:0] last_s;
  logic        last_cout, last_ovf;

  addsub_seq_s #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .overflow(overflow), .busy(busy)
  );

  addsub_seq_s #(.WIDTH(32), .SLICE(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .sub(sub32), .cin(cin32), .out_valid(out_valid32),
    .out_ready(out_ready32), .s(s32), .cout(cout32), .overflow(overflow32),
    .busy(busy32)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Signed arithmetic on full integers; overflow = true result out of range.
  function automatic void ref_op(input int w, input logic [63:0] ra, input logic [63:0] rb,
                                 input logic rsub, input logic rcin,
                                 output logic [63:0] rs, output logic rco, output logic rov);
    longint mask, sa, sb, r, hi, lo, ua, ub, us;
    mask = (longint'(1) <<< w) - 1;
    sa = longint'(ra << (64 - w)) >>> (64 - w);
    sb = longint'(rb << (64 - w)) >>> (64 - w);
    r  = rsub ? (sa - sb - longint'(rcin)) : (sa + sb + longint'(rcin));
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    rs  = 64'(r & mask);
    rov = (r > hi) || (r < lo);
    ua = longint'(ra) & mask;
    ub = rsub ? (~longint'(rb) & mask) : (longint'(rb) & mask);
    us = ua + ub + longint'(rcin ^ rsub);
    rco = us[w];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Presents an operand set and returns just before the accepting edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                      input logic ts, input logic tc);
    int k;
    logic [63:0] es;
    logic eco, eov;
    tick();
    a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      ref_op(16, 64'(ta), 64'(tb), ts, tc, es, eco, eov);
      exp_q.push_back({eov, eco, es[15:0]});
      acc_edge = cyc + 1;
    end
  endtask

  task automatic send_one(input logic [15:0] ta, input logic [15:0] tb,
                          input logic ts, input logic tc);
    send(ta, tb, ts, tc);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int target);
    int k;
    k = 0;
    while (n_results < target && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("result_timeout", 64'(n_results >= target), 64'd1);
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev)
        chk("latency", 64'(cyc + 1 - acc_edge), 64'd5);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(exp_q.size()), 64'd1);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("s", 64'(s), 64'(e[15:0]));
          chk("cout", 64'(cout), 64'(e[16]));
          chk("overflow", 64'(overflow), 64'(e[17]));
        end
        last_s = s; last_cout = cout; last_ovf = overflow;
        n_results++;
      end
      ov_prev = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, prev_acc, k, start;
    logic [15:0] hs;
    logic ho, hc;
    logic [63:0] es;
    logic eco, eov;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    out_ready = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; cin32 = 1'b0; out_ready32 = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    tick();
    rst_n = 1'b1;

    // Model pins against hand-computed values
    ref_op(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0, es, eco, eov);
    chk("model_pin1", {es[15:0], eco, eov}, {16'h8000, 1'b0, 1'b1});
    ref_op(16, 64'hFFFD, 64'h0005, 1'b0, 1'b1, es, eco, eov);
    chk("model_pin2", {es[15:0], eco, eov}, {16'h0003, 1'b1, 1'b0});

    // Directed vectors with literal expectations
    send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_result(1);
    chk("t1_s", 64'(last_s), 64'h8000);
    chk("t1_ovf", 64'(last_ovf), 64'd1);
    chk("t1_cout", 64'(last_cout), 64'd0);

    send_one(16'h8000, 16'h0001, 1'b1, 1'b0);
    wait_result(2);
    chk("t2a_s", 64'(last_s), 64'h7FFF);
    chk("t2a_ovf", 64'(last_ovf), 64'd1);
    chk("t2a_cout", 64'(last_cout), 64'd1);

    send_one(16'hFFFD, 16'h0005, 1'b0, 1'b1);
    wait_result(3);
    chk("t2b_s", 64'(last_s), 64'h0003);
    chk("t2b_ovf", 64'(last_ovf), 64'd0);
    chk("t2b_cout", 64'(last_cout), 64'd1);

    send_one(16'h0000, 16'h0000, 1'b1, 1'b1);
    wait_result(4);
    chk("t2c_s", 64'(last_s), 64'hFFFF);
    chk("t2c_ovf", 64'(last_ovf), 64'd0);

    // Backpressure: result held while out_ready is low, operand pulses ignored
    out_ready = 1'b0;
    send_one(16'h1234, 16'h4321, 1'b0, 1'b0);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_reach_done", 64'(out_valid), 64'd1);
    hs = s; ho = overflow; hc = cout;
    chk("bp_s", 64'(hs), 64'h5555);
    for (int i = 0; i < 10; i++) begin
      tick();
      in_valid = i[0];
      a = 16'(i * 16'h1111); b = 16'hAAAA;
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold", {s, overflow, cout}, {hs, ho, hc});
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_results", 64'(n_results), 64'd5);

    // Asynchronous reset while the third slice is pending
    send_one(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    start = n_results;
    send_one(16'h0002, 16'h0003, 1'b0, 1'b0);
    wait_result(start + 1);
    chk("post_rst_s", 64'(last_s), 64'h0005);
    repeat (8) @(negedge clk);
    chk("post_rst_count", 64'(n_results - start), 64'd1);

    // Back-to-back random operations, in_valid and out_ready held high
    base = n_results;
    prev_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i > 0 && (i % 50) == 0)
        chk("throughput", 64'(acc_edge - prev_acc), 64'd6);
      prev_acc = acc_edge;
    end
    tick();
    in_valid = 1'b0;
    wait_result(base + 1000);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // 32/8 instance
    for (int v = 0; v < 2; v++) begin
      logic [31:0] va, vb;
      logic vs;
      int acc32;
      va = (v == 0) ? 32'h7FFFFFFF : 32'h80000000;
      vb = 32'h00000001;
      vs = (v == 1);
      tick();
      a32 = va; b32 = vb; sub32 = vs; cin32 = 1'b0; in_valid32 = 1'b1;
      chk("w32_in_ready", 64'(in_ready32), 64'd1);
      acc32 = cyc + 1;
      tick();
      in_valid32 = 1'b0;
      k = 0;
      @(negedge clk);
      while (!out_valid32 && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("w32_latency", 64'(cyc + 1 - acc32), 64'd5);
      ref_op(32, 64'(va), 64'(vb), vs, 1'b0, es, eco, eov);
      chk("w32_model", {s32, cout32, overflow32}, {es[31:0], eco, eov});
      chk("w32_s_lit", 64'(s32), (v == 0) ? 64'h80000000 : 64'h7FFFFFFF);
      chk("w32_ovf_lit", 64'(overflow32), 64'd1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
